// File: rtl/fft_frame_reader.sv
// fft_frame_reader: read-side controller for the burst FFT/IFFT result buffer.
// After a start pulse it scans every buffer location once and presents the RAM's
// registered read port as a valid/ready stream with a last flag. Under
// backpressure it stalls the RAM output register through the read clock enable,
// so no skid buffer is needed.
// Build option: define FFT_FRAME_READER_BITREV_EN to read the buffer in
// bit-reversed address order. Natural order is the default.
module fft_frame_reader #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_clk_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  frame_done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_CNT = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ONE_CNT  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                  state_r;
   logic [ADDR_WIDTH-1:0]   cnt_r;
   logic                    adv_s;
   logic                    rd_en_s;
   logic                    last_hs_s;

   // Map the scan counter onto a buffer address (identity or bit-reverse).
   function automatic logic [ADDR_WIDTH-1:0] addr_map(input logic [ADDR_WIDTH-1:0] c);
      logic [ADDR_WIDTH-1:0] r;
`ifdef FFT_FRAME_READER_BITREV_EN
      r = {ADDR_WIDTH{1'b0}};
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         r[i] = c[ADDR_WIDTH-1-i];
      end
`else
      r = c;
`endif
      return r;
   endfunction

   // Advance when the output slot is empty or is being emptied this cycle.
   always_comb begin
      adv_s     = ~out_valid | out_ready;
      last_hs_s = out_valid & out_ready & out_last;
      if (rst_n && (state_r == RUN)) begin
         rd_en_s = adv_s;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   assign rd_clk_en = rd_en_s;
   assign rd_addr   = addr_map(cnt_r);
   // The RAM output register is the stream register; it holds while rd_clk_en is low.
   assign out_data  = rd_data;

   // Frame sequencing FSM, read counter and registered stream/status flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= {ADDR_WIDTH{1'b0}};
         busy       <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         if (rd_en_s) begin
            cnt_r     <= cnt_r + ONE_CNT;
            out_valid <= 1'b1;
            out_last  <= (cnt_r == LAST_CNT);
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         case (state_r)
            IDLE: begin
               // A start arriving while frame_done pulses belongs to the old frame.
               if (start && !frame_done) begin
                  state_r <= RUN;
                  cnt_r   <= {ADDR_WIDTH{1'b0}};
                  busy    <= 1'b1;
               end
            end
            RUN: begin
               if (rd_en_s && (cnt_r == LAST_CNT)) begin
                  state_r <= DRAIN;
               end
            end
            DRAIN: begin
               if (last_hs_s) begin
                  state_r    <= IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
